// File: rtl/regfile_tagged_mp_if.sv
// regfile_tagged_mp_if: read, write, reserve and busy-count signals of the tagged register file
interface regfile_tagged_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int TAG_W  = 4
);
  logic              clear_i;
  logic [ADDR_W-1:0] rs_addr_i;
  logic [ADDR_W-1:0] rt_addr_i;
  logic [DATA_W-1:0] rs_data_o;
  logic [DATA_W-1:0] rt_data_o;
  logic              rs_busy_o;
  logic              rt_busy_o;
  logic [ADDR_W-1:0] op_addr_i;
  logic [DATA_W-1:0] op_data_o;
  logic [TAG_W-1:0]  op_tag_o;
  logic              wa_en_i;
  logic [ADDR_W-1:0] wa_addr_i;
  logic [DATA_W-1:0] wa_data_i;
  logic [TAG_W-1:0]  wa_tag_i;
  logic              wb_en_i;
  logic [ADDR_W-1:0] wb_addr_i;
  logic [DATA_W-1:0] wb_data_i;
  logic [TAG_W-1:0]  wb_tag_i;
  logic              rsv_en_i;
  logic [ADDR_W-1:0] rsv_addr_i;
  logic [ADDR_W:0]   busy_cnt_o;
  modport master (
    output clear_i, rs_addr_i, rt_addr_i, op_addr_i,
    output wa_en_i, wa_addr_i, wa_data_i, wa_tag_i,
    output wb_en_i, wb_addr_i, wb_data_i, wb_tag_i,
    output rsv_en_i, rsv_addr_i,
    input  rs_data_o, rt_data_o, rs_busy_o, rt_busy_o, op_data_o, op_tag_o, busy_cnt_o
  );
  modport slave (
    input  clear_i, rs_addr_i, rt_addr_i, op_addr_i,
    input  wa_en_i, wa_addr_i, wa_data_i, wa_tag_i,
    input  wb_en_i, wb_addr_i, wb_data_i, wb_tag_i,
    input  rsv_en_i, rsv_addr_i,
    output rs_data_o, rt_data_o, rs_busy_o, rt_busy_o, op_data_o, op_tag_o, busy_cnt_o
  );
endinterface

// File: rtl/regfile_tagged_mp.sv
// regfile_tagged_mp: two-write, three-read tagged register file with busy scoreboard and counter
module regfile_tagged_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int TAG_W    = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input logic               clk_i,
  input logic               reset,
  regfile_tagged_mp_if.slave rf
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = ADDR_W + 1;
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [TAG_W-1:0]  t;
    logic              b;
  } rd_t;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [TAG_W-1:0]  tag_d  [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wa_v, wb_v, rsv_v, inc, wa_rel, wb_rel;
  rd_t               rs_r, rt_r, op_r;
  function automatic logic live(input logic [ADDR_W-1:0] a);
    return !(ZERO_REG != 0 && a == '0);
  endfunction
  // Stored view of an entry, overridden by same-cycle writes when bypass is enabled; zero in reset
  function automatic rd_t rd(input logic [ADDR_W-1:0] a);
    rd_t r;
    r.d = data_q[a];
    r.t = tag_q[a];
    r.b = busy_q[a];
    if (BYPASS != 0 && wb_v && rf.wb_addr_i == a) begin
      r.d = rf.wb_data_i;
      r.t = rf.wb_tag_i;
      r.b = rsv_v && rf.rsv_addr_i == a;
    end else if (BYPASS != 0 && wa_v && rf.wa_addr_i == a) begin
      r.d = rf.wa_data_i;
      r.t = rf.wa_tag_i;
      r.b = rsv_v && rf.rsv_addr_i == a;
    end
    if (reset || !live(a))
      r = '0;
    return r;
  endfunction
  // Qualify requests so the hardwired zero entry is never written, reserved or released
  always_comb begin
    wa_v  = rf.wa_en_i && live(rf.wa_addr_i);
    wb_v  = rf.wb_en_i && live(rf.wb_addr_i);
    rsv_v = rf.rsv_en_i && live(rf.rsv_addr_i);
  end
  // Per-entry next state: port B beats port A, reserve beats release, clear beats both
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = wb_v && rf.wb_addr_i == ADDR_W'(i) ? rf.wb_data_i :
                  wa_v && rf.wa_addr_i == ADDR_W'(i) ? rf.wa_data_i : data_q[i];
      tag_d[i]  = wb_v && rf.wb_addr_i == ADDR_W'(i) ? rf.wb_tag_i :
                  wa_v && rf.wa_addr_i == ADDR_W'(i) ? rf.wa_tag_i : tag_q[i];
      busy_d[i] = !rf.clear_i &&
                  ((rsv_v && rf.rsv_addr_i == ADDR_W'(i)) ||
                   (busy_q[i] && !(wa_v && rf.wa_addr_i == ADDR_W'(i))
                              && !(wb_v && rf.wb_addr_i == ADDR_W'(i))));
    end
  end
  // Incremental count: +1 for a reserve of an idle entry, -1 per distinct busy entry released
  always_comb begin
    inc    = rsv_v && !busy_q[rf.rsv_addr_i];
    wa_rel = wa_v && busy_q[rf.wa_addr_i] && !(rsv_v && rf.rsv_addr_i == rf.wa_addr_i);
    wb_rel = wb_v && busy_q[rf.wb_addr_i] && !(rsv_v && rf.rsv_addr_i == rf.wb_addr_i)
                  && !(wa_rel && rf.wa_addr_i == rf.wb_addr_i);
    cnt_d  = rf.clear_i ? '0 : cnt_q + CW'(inc) - CW'(wa_rel) - CW'(wb_rel);
  end
  // State registers; reset wipes data, tags, scoreboard and counter
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end
  // Three combinational read ports
  always_comb begin
    rs_r = rd(rf.rs_addr_i);
    rt_r = rd(rf.rt_addr_i);
    op_r = rd(rf.op_addr_i);
  end
  assign rf.rs_data_o  = rs_r.d;
  assign rf.rs_busy_o  = rs_r.b;
  assign rf.rt_data_o  = rt_r.d;
  assign rf.rt_busy_o  = rt_r.b;
  assign rf.op_data_o  = op_r.d;
  assign rf.op_tag_o   = op_r.t;
  assign rf.busy_cnt_o = cnt_q;
endmodule

// File: doc/regfile_tagged_mp.md
# regfile_tagged_mp

Parametrised, multi-ported tagged register file for the datapath. It supersedes the single-write-port, negedge-written file. It has:
- two posedge write ports with fixed priority
- two operand read ports plus a debug/operand-fetch read port
- per-entry tag (position) storage
- optional write-through bypass
- a per-entry busy scoreboard with a registered busy counter, so issue logic can stall on pending writes

It sits between decode/issue (read and reserve) and writeback (write and release).

## Interface
- DATA_W, 32, data width per entry
- ADDR_W, 5, address width; depth = 2**ADDR_W
- TAG_W, 4, tag (position) width per entry
- ZERO_REG, 1, 1 = entry 0 reads all-zero and is never written or busy
- BYPASS, 0, 1 = same-cycle write data forwarded to read ports
- clk_i  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous clear of busy bits and busy counter only
- rs_addr_i, rt_addr_i  in  ADDR_W  operand read addresses
- rs_data_o, rt_data_o  out  DATA_W  operand read data (combinational)
- rs_busy_o, rt_busy_o  out  1  busy bit of addressed entry
- op_addr_i  in  ADDR_W  debug/operand-fetch address
- op_data_o  out  DATA_W  data of op_addr_i entry
- op_tag_o  out  TAG_W  tag of op_addr_i entry
- wa_en_i, wb_en_i  in  1  write enables, port A / port B
- wa_addr_i, wb_addr_i  in  ADDR_W  write addresses
- wa_data_i, wb_data_i  in  DATA_W  write data
- wa_tag_i, wb_tag_i  in  TAG_W  write tags
- rsv_en_i  in  1  reserve request (mark entry pending)
- rsv_addr_i  in  ADDR_W  entry to reserve
- busy_cnt_o  out  ADDR_W+1  registered count of busy entries

## Operation
- Storage:
  - data[2**ADDR_W], tag[2**ADDR_W], busy[2**ADDR_W].
- Writes:
  - Each enabled port writes data and tag at its address on the rising edge.
  - Both ports to the same address: port B wins for both data and tag.
- Release:
  - Any enabled write clears that entry's busy bit.
- Reserve:
  - rsv_en_i sets busy[rsv_addr_i].
  - Reserve and write to the same entry in the same cycle: reserve wins, and busy stays 1.
- ZERO_REG=1:
  - Writes and reserves to entry 0 are ignored.
  - Reads of entry 0 return data 0, tag 0, busy 0.
- Reads:
  - Reads are combinational from stored state.
  - With BYPASS=1, an enabled write to the read address in the current cycle supplies data and tag, with port B taking precedence.
  - With BYPASS=1, that read sees busy = 0 unless rsv_en_i targets the same entry.
  - Bypass never applies to entry 0 when ZERO_REG=1.
- busy_cnt_o:
  - Equals the number of set busy bits after each edge.
  - Updated incrementally as +1 per newly set bit and −1 per newly cleared bit, net per cycle.
  - Must match popcount(busy) at every cycle.
- clear_i:
  - Clears all busy bits and busy_cnt_o to 0.
  - Overrides reserve and release in the same cycle.
  - Data and tags are untouched.
  - Writes still occur.
- Reset:
  - Asynchronously zeroes all data, tags and busy bits, and busy_cnt_o.
  - All read outputs therefore read 0 during and after reset.
  - Reset asserted mid-cycle discards in-flight writes and reserves.

## Timing
- Write latency:
  - BYPASS=0: write data and tag are visible on read ports 1 cycle after the edge.
  - BYPASS=1: visible combinationally in the same cycle.
- Reserve/release:
  - Stored busy is visible 1 cycle after the edge.
  - busy_cnt_o updates on the same edge.
- No handshake: every enabled request is accepted every cycle, with no back-pressure.
- Reset deassertion: first state update on the next rising edge.
- Busy counter:
  - Cannot overflow; its maximum is 2**ADDR_W, or 2**ADDR_W−1 with ZERO_REG.
  - Reserving an already-busy entry does not change the count.
  - Releasing an idle entry does not change the count.

## Test plan
- Reset, then write A addr 3 = 0xDEADBEEF tag 0x5 → next cycle rs_data_o=0xDEADBEEF, op_tag_o=0x5 (op_addr_i=3), all other entries read 0.
- Write A and B to addr 7 the same cycle (0x1111/tag 1, 0x2222/tag 2) → addr 7 holds 0x2222, tag 2; with BYPASS=1, rs_data_o=0x2222 in the write cycle itself.
- ZERO_REG=1: write 0xFFFFFFFF to addr 0 and reserve addr 0 → rs_data_o=0, rs_busy_o=0, busy_cnt_o unchanged.
- Reserve addr 4, 5, 6 on consecutive cycles → busy_cnt_o 1,2,3. Then write addr 5 and reserve addr 5 in the same cycle → busy stays 1, count 3. Then write addr 4 → count 2.
- With 3 entries busy, assert clear_i together with reserve addr 9 and write addr 2 → busy_cnt_o=0, all busy 0, addr 2 data updated.
- Assert reset between edges with writes pending → no writes land, all outputs 0, busy_cnt_o=0 immediately.
